// File: rtl/regfile_wb_arbiter.sv
// Round-robin sharing of the single regfile write port among NREQ writeback units,
// plus a pending-write scoreboard for RAW stalls. Define WB_BYPASS_EN for forwarding outputs.
module regfile_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 issue_valid,
    input  logic [AW-1:0]        issue_addr,
    input  logic [AW-1:0]        chk_addr1,
    input  logic [AW-1:0]        chk_addr2,
    output logic                 stall,
`ifdef WB_BYPASS_EN
    output logic                 fwd_hit1,
    output logic                 fwd_hit2,
    output logic [DW-1:0]        fwd_data1,
    output logic [DW-1:0]        fwd_data2,
`endif
    output logic                 rf_we,
    output logic [AW-1:0]        rf_waddr,
    output logic [DW-1:0]        rf_wdata,
    output logic [(2**AW)-1:0]   pending
);

    localparam int PW   = (NREQ > 2) ? 2 : 1;
    localparam int NREG = 2 ** AW;

    logic [PW-1:0]   rr_ptr_r;
    logic [NREQ-1:0] grant_s;
    logic [PW-1:0]   gidx_s;
    logic            found_s;
    int              idx_s;
    logic [AW-1:0]   gaddr_s;
    logic [DW-1:0]   gdata_s;
    logic            xfer_s;
    logic [NREG-1:0] pending_r;
    logic [NREG-1:0] pending_nxt_s;
    logic            rf_we_r;
    logic [AW-1:0]   rf_waddr_r;
    logic [DW-1:0]   rf_wdata_r;
    logic            src1_s;
    logic            src2_s;

    // Round-robin scan from rr_ptr; reset suppresses every grant.
    always_comb begin
        grant_s = {NREQ{1'b0}};
        gidx_s  = {PW{1'b0}};
        found_s = 1'b0;
        idx_s   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx_s = (int'(rr_ptr_r) + k) % NREQ;
            if (!found_s && req_valid[idx_s]) begin
                grant_s[idx_s] = 1'b1;
                gidx_s         = PW'(idx_s);
                found_s        = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
        if (rst) begin
            grant_s = {NREQ{1'b0}};
            found_s = 1'b0;
        end else begin
            grant_s = grant_s;
        end
    end

    assign xfer_s    = found_s;
    assign gaddr_s   = req_addr[int'(gidx_s)*AW +: AW];
    assign gdata_s   = req_data[int'(gidx_s)*DW +: DW];
    assign req_ready = grant_s;

    // Scoreboard update: a new issue to the same register wins over the retiring write.
    always_comb begin
        pending_nxt_s = pending_r;
        if (xfer_s) begin
            pending_nxt_s[gaddr_s] = 1'b0;
        end else begin
            pending_nxt_s = pending_nxt_s;
        end
        if (issue_valid && (issue_addr != {AW{1'b0}})) begin
            pending_nxt_s[issue_addr] = 1'b1;
        end else begin
            pending_nxt_s = pending_nxt_s;
        end
        pending_nxt_s[0] = 1'b0;
    end

    // State: round-robin pointer, registered write port, scoreboard.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_r   <= {PW{1'b0}};
            rf_we_r    <= 1'b0;
            rf_waddr_r <= {AW{1'b0}};
            rf_wdata_r <= {DW{1'b0}};
            pending_r  <= {NREG{1'b0}};
        end else begin
            pending_r <= pending_nxt_s;
            if (xfer_s) begin
                rr_ptr_r   <= PW'((int'(gidx_s) + 1) % NREQ);
                rf_we_r    <= (gaddr_s != {AW{1'b0}});
                rf_waddr_r <= gaddr_s;
                rf_wdata_r <= gdata_s;
            end else begin
                rf_we_r <= 1'b0;
            end
        end
    end

    assign rf_we    = rf_we_r;
    assign rf_waddr = rf_waddr_r;
    assign rf_wdata = rf_wdata_r;
    assign pending  = pending_r;

    assign src1_s = (chk_addr1 != {AW{1'b0}}) && pending_r[chk_addr1];
    assign src2_s = (chk_addr2 != {AW{1'b0}}) && pending_r[chk_addr2];

`ifdef WB_BYPASS_EN
    // A source being written this cycle is served from the forwarding path instead of stalling.
    assign fwd_hit1  = rf_we_r && (rf_waddr_r == chk_addr1) && (chk_addr1 != {AW{1'b0}});
    assign fwd_hit2  = rf_we_r && (rf_waddr_r == chk_addr2) && (chk_addr2 != {AW{1'b0}});
    assign fwd_data1 = rf_wdata_r;
    assign fwd_data2 = rf_wdata_r;
    assign stall     = (src1_s && !fwd_hit1) || (src2_s && !fwd_hit2);
`else
    assign stall     = src1_s || src2_s;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected writes are queued at grant time
// and compared against the registered write port one cycle later.
module tb_regfile_wb_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   req_valid;
    logic [14:0]  req_addr;
    logic [95:0]  req_data;
    logic [2:0]   req_ready;
    logic         issue_valid;
    logic [4:0]   issue_addr;
    logic [4:0]   chk_addr1;
    logic [4:0]   chk_addr2;
    logic         stall;
    logic         rf_we;
    logic [4:0]   rf_waddr;
    logic [31:0]  rf_wdata;
    logic [31:0]  pending;
`ifdef WB_BYPASS_EN
    logic         fwd_hit1;
    logic         fwd_hit2;
    logic [31:0]  fwd_data1;
    logic [31:0]  fwd_data2;
`endif

    regfile_wb_arbiter #(.NREQ(3), .AW(5), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
        .issue_valid(issue_valid), .issue_addr(issue_addr),
        .chk_addr1(chk_addr1), .chk_addr2(chk_addr2), .stall(stall),
`ifdef WB_BYPASS_EN
        .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2), .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
`endif
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pending(pending)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         sb_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_pend;
    logic [4:0]  last_addr;
    logic [31:0] last_data;
    logic        hold_ok;

    localparam logic [14:0] RR_A = {5'd12, 5'd11, 5'd10};
    localparam logic [95:0] RR_D = {32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: check the grant, queue the expected write, then check the write port.
    task automatic step(input string tag, input logic [2:0] v, input logic [14:0] a,
                        input logic [95:0] d, input logic iv, input logic [4:0] ia,
                        input logic [2:0] exp_gnt);
        wr_t w;
        req_valid = v; req_addr = a; req_data = d; issue_valid = iv; issue_addr = ia;
        #1;
        chk({tag, ".gnt"}, 64'(req_ready), 64'(exp_gnt));
        for (int i = 0; i < 3; i++) begin
            if (exp_gnt[i]) begin
                w.addr = a[i*5 +: 5];
                w.data = d[i*32 +: 32];
                w.we   = (w.addr != 5'd0);
                sb_q.push_back(w);
                exp_pend[w.addr] = 1'b0;
            end
        end
        if (iv && (ia != 5'd0)) exp_pend[ia] = 1'b1;
        @(posedge clk); #1;
        req_valid = 3'b000; issue_valid = 1'b0;
        if (sb_q.size() > 0) begin
            w = sb_q.pop_front();
            chk({tag, ".we"}, 64'(rf_we), 64'(w.we));
            if (w.we) begin
                chk({tag, ".waddr"}, 64'(rf_waddr), 64'(w.addr));
                chk({tag, ".wdata"}, 64'(rf_wdata), 64'(w.data));
            end
            last_addr = w.addr; last_data = w.data; hold_ok = w.we;
        end else begin
            chk({tag, ".idle_we"}, 64'(rf_we), 64'd0);
            if (hold_ok) begin
                chk({tag, ".hold_addr"}, 64'(rf_waddr), 64'(last_addr));
                chk({tag, ".hold_data"}, 64'(rf_wdata), 64'(last_data));
            end
        end
        chk({tag, ".pending"}, 64'(pending), 64'(exp_pend));
    endtask

    task automatic check_stall(input string tag, input logic [4:0] c1, input logic [4:0] c2,
                               input logic e);
        chk_addr1 = c1; chk_addr2 = c2;
        #1;
        chk(tag, 64'(stall), 64'(e));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; req_valid = 3'b111; req_addr = RR_A; req_data = RR_D;
        issue_valid = 1'b0; issue_addr = 5'd0; chk_addr1 = 5'd0; chk_addr2 = 5'd0;
        exp_pend = 32'd0; last_addr = 5'd0; last_data = 32'd0; hold_ok = 1'b0;

        // Reset held two cycles with all requesters valid
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            chk("rst.ready", 64'(req_ready), 64'd0);
            chk("rst.we", 64'(rf_we), 64'd0);
            chk("rst.pending", 64'(pending), 64'd0);
        end
        chk("rst.waddr", 64'(rf_waddr), 64'd0);
        chk("rst.wdata", 64'(rf_wdata), 64'd0);
        rst = 1'b0;

        // Round robin, first grant to index 0
        step("rr0", 3'b111, RR_A, RR_D, 1'b0, 5'd0, 3'b001);
        step("rr1", 3'b111, RR_A, RR_D, 1'b0, 5'd0, 3'b010);
        step("rr2", 3'b111, RR_A, RR_D, 1'b0, 5'd0, 3'b100);
        step("rr3", 3'b111, RR_A, RR_D, 1'b0, 5'd0, 3'b001);
        step("rr4", 3'b111, RR_A, RR_D, 1'b0, 5'd0, 3'b010);
        step("rr5", 3'b111, RR_A, RR_D, 1'b0, 5'd0, 3'b100);

        // Single write, then an idle cycle with held address/data
        step("single", 3'b001, {10'd0, 5'd5}, {64'd0, 32'hDEADBEEF}, 1'b0, 5'd0, 3'b001);
        step("idle", 3'b000, 15'd0, 96'd0, 1'b0, 5'd0, 3'b000);

        // Address 0 completes the handshake without a write (rr_ptr=1 wraps to ALU)
        step("addr0", 3'b001, 15'd0, {64'd0, 32'h1}, 1'b0, 5'd0, 3'b001);

        // Scoreboard set, stall, clear by MDU
        step("iss7", 3'b000, 15'd0, 96'd0, 1'b1, 5'd7, 3'b000);
        check_stall("stall.src1", 5'd7, 5'd0, 1'b1);
        check_stall("stall.src2", 5'd0, 5'd7, 1'b1);
        check_stall("stall.none", 5'd8, 5'd0, 1'b0);
        step("mdu7", 3'b010, {5'd0, 5'd7, 5'd0}, {32'd0, 32'h77, 32'd0}, 1'b0, 5'd0, 3'b010);
        check_stall("stall.clr", 5'd7, 5'd7, 1'b0);

        // Same-cycle issue and transfer to 9: set wins
        step("setwin9", 3'b100, {5'd9, 10'd0}, {32'h99, 64'd0}, 1'b1, 5'd9, 3'b100);
        check_stall("stall.9", 5'd0, 5'd9, 1'b1);

        // Build rr_ptr=2 and pending[3]=1 before a mid-operation reset
        step("iss3", 3'b001, {10'd0, 5'd4}, {64'd0, 32'h44}, 1'b1, 5'd3, 3'b001);
        step("mdu6", 3'b010, {5'd0, 5'd6, 5'd0}, {32'd0, 32'h66, 32'd0}, 1'b0, 5'd0, 3'b010);

        rst = 1'b1; req_valid = 3'b110; req_addr = {5'd13, 5'd14, 5'd0};
        req_data = {32'h1313, 32'h1414, 32'd0};
        #1;
        chk("mid.ready", 64'(req_ready), 64'd0);
        chk("mid.prev_we", 64'(rf_we), 64'd1);
        chk("mid.prev_addr", 64'(rf_waddr), 64'd6);
        @(posedge clk); #1;
        chk("mid.pending", 64'(pending), 64'd0);
        chk("mid.we", 64'(rf_we), 64'd0);
        chk("mid.waddr", 64'(rf_waddr), 64'd0);
        rst = 1'b0; exp_pend = 32'd0; hold_ok = 1'b0;
        step("post_rst", 3'b110, {5'd13, 5'd14, 5'd0}, {32'h1313, 32'h1414, 32'd0},
             1'b0, 5'd0, 3'b010);

        chk("sb.empty", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
